// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman host and player controllers.
package hangman_pkg;
  typedef enum logic [1:0] {ST_ENTRY, ST_LOCK, ST_PLAY, ST_RESULT} state_e;

  localparam int         WORD_LEN   = 5;
  localparam logic [7:0] UNDERSCORE = 8'h5F;
  localparam logic [7:0] LETTER_A   = 8'h41;
  localparam logic [7:0] LETTER_Z   = 8'h5A;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= LETTER_A) && (c <= LETTER_Z);
  endfunction
endpackage

// File: rtl/hangman_match.sv
// Compares one letter against every position of a packed word; bit i is the i-th entered letter.
module hangman_match
  import hangman_pkg::*;
(
  input  logic [8*WORD_LEN-1:0] word,
  input  logic [7:0]            letter,
  output logic [WORD_LEN-1:0]   mask
);
  for (genvar i = 0; i < WORD_LEN; i++) begin : g_pos
    assign mask[i] = (word[8*(WORD_LEN-1-i) +: 8] == letter);
  end
endmodule

// File: rtl/host_game_ctrl.sv
// Host-side hangman round sequencer: word entry, lock, guess scoring, result hold.
//  state     | meaning
//  ST_ENTRY  | forwarding keypad letters, waiting for submit
//  ST_LOCK   | waiting for the message register to enter compare mode
//  ST_PLAY   | scoring guesses against the latched word
//  ST_RESULT | holding win/lose before ending the round
module host_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_MISTAKES  = 6,
  parameter int RESULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        key_ready,
  input  logic [7:0]  key_letter,
  input  logic        submit,
  input  logic [39:0] word,
  input  logic        word_ready,
  input  logic        guess_valid,
  input  logic [7:0]  guess,
  output logic        reg_key_ready,
  output logic        reg_toggle,
  output logic        game_end,
  output logic        guess_ack,
  output logic [39:0] reveal,
  output logic [2:0]  mistakes,
  output logic        win,
  output logic        lose
);
  localparam int            TW            = $clog2(RESULT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD    = TW'(RESULT_CYCLES - 1);
  localparam logic [2:0]    MISTAKE_LIMIT = 3'(MAX_MISTAKES);
  localparam logic [2:0]    FULL_COUNT    = 3'(WORD_LEN);

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [39:0]   word_q, word_d;
  logic [4:0]    revealed_q, revealed_d;
  logic [25:0]   guessed_q, guessed_d;
  logic [2:0]    mistakes_q, mistakes_d;
  logic          win_q, win_d, lose_q, lose_d;
  logic          reg_toggle_q, reg_toggle_d;
  logic          game_end_q, game_end_d;
  logic          guess_ack_q, guess_ack_d;

  logic [4:0] match_mask;
  logic [4:0] revealed_next;
  logic [4:0] guess_idx;
  logic       key_ok;
  logic       round_end;

  hangman_match u_match (
    .word   (word_q),
    .letter (guess),
    .mask   (match_mask)
  );

  assign revealed_next = revealed_q | match_mask;
  assign guess_idx     = 5'(guess - LETTER_A);
  assign key_ok        = (state_q == ST_ENTRY) && key_ready &&
                         (count_q < FULL_COUNT) && is_upper(key_letter);
  assign reg_key_ready = key_ok;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timer_d      = timer_q;
    word_d       = word_q;
    revealed_d   = revealed_q;
    guessed_d    = guessed_q;
    mistakes_d   = mistakes_q;
    win_d        = win_q;
    lose_d       = lose_q;
    reg_toggle_d = 1'b0;
    game_end_d   = 1'b0;
    guess_ack_d  = 1'b0;
    round_end    = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (key_ok) begin
          count_d = count_q + 3'd1;
        end else if (submit && !key_ready && (count_q == FULL_COUNT)) begin
          reg_toggle_d = 1'b1;
          state_d      = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (word_ready) begin
          word_d  = word;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (guess_valid) begin
          guess_ack_d = 1'b1;
          if (is_upper(guess) && !guessed_q[guess_idx]) begin
            guessed_d[guess_idx] = 1'b1;
            if (|match_mask) begin
              revealed_d = revealed_next;
              if (&revealed_next) begin
                win_d     = 1'b1;
                round_end = 1'b1;
              end
            end else begin
              mistakes_d = mistakes_q + 3'd1;
              if (mistakes_d == MISTAKE_LIMIT) begin
                lose_d    = 1'b1;
                round_end = 1'b1;
              end
            end
          end
        end
        if (round_end) begin
          state_d    = ST_RESULT;
          timer_d    = TIMER_LOAD;
          // a one-cycle hold means the end pulse coincides with the first result cycle
          game_end_d = (TIMER_LOAD == '0);
        end
      end
      ST_RESULT: begin
        if (timer_q == '0) begin
          state_d    = ST_ENTRY;
          count_d    = '0;
          guessed_d  = '0;
          mistakes_d = '0;
          revealed_d = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
        end else begin
          timer_d    = timer_q - TW'(1);
          game_end_d = (timer_q == TW'(1));
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q      <= ST_ENTRY;
      count_q      <= '0;
      timer_q      <= '0;
      word_q       <= '0;
      revealed_q   <= '0;
      guessed_q    <= '0;
      mistakes_q   <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      reg_toggle_q <= 1'b0;
      game_end_q   <= 1'b0;
      guess_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      word_q       <= word_d;
      revealed_q   <= revealed_d;
      guessed_q    <= guessed_d;
      mistakes_q   <= mistakes_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      reg_toggle_q <= reg_toggle_d;
      game_end_q   <= game_end_d;
      guess_ack_q  <= guess_ack_d;
    end
  end

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_reveal
    assign reveal[8*(WORD_LEN-1-i) +: 8] = revealed_q[i] ? word_q[8*(WORD_LEN-1-i) +: 8] : UNDERSCORE;
  end

  assign reg_toggle = reg_toggle_q;
  assign game_end   = game_end_q;
  assign guess_ack  = guess_ack_q;
  assign mistakes   = mistakes_q;
  assign win        = win_q;
  assign lose       = lose_q;
endmodule

// File: doc/host_game_ctrl.md
# host_game_ctrl

Host-side game controller for wireless hangman. Sequences the host message register through word entry, then scores incoming guesses against the locked word, tracks revealed letters and mistakes, and ends the round. Sits between the keypad/radio receive path and the host message register and display.

## Interface

Parameters:
- MAX_MISTAKES, 6, wrong guesses that end the round in a loss (1..7)
- RESULT_CYCLES, 4, cycles to hold win/lose before ending the round (≥1)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- nRst  in  1  synchronous active-low reset
- key_ready  in  1  keypad letter strobe
- key_letter  in  8  ASCII letter from keypad
- submit  in  1  host confirm strobe
- word  in  40  message register contents
- word_ready  in  1  message register in compare mode
- guess_valid  in  1  received guess strobe
- guess  in  8  ASCII guess letter
- reg_key_ready  out  1  gated key strobe to message register
- reg_toggle  out  1  one-cycle pulse that locks the message register
- game_end  out  1  one-cycle round-end pulse to message register and radio
- guess_ack  out  1  one-cycle acknowledge of a processed guess
- reveal  out  40  display word; hidden letters are 8'h5F
- mistakes  out  3  wrong-guess count
- win  out  1  round won (held in RESULT)
- lose  out  1  round lost (held in RESULT)

## Operation

- States: ENTRY → LOCK → PLAY → RESULT → ENTRY.
- ENTRY: letter count 0..5.
  - reg_key_ready = key_ready when count<5 and key_letter is in 8'h41..8'h5A; count increments on each forwarded key. Other keys are dropped.
  - submit is accepted only when count==5 and key_ready is low that cycle (a key takes priority). Acceptance pulses reg_toggle for 1 cycle and moves to LOCK.
- LOCK: wait for word_ready. On word_ready, latch word into an internal copy and go to PLAY.
  - Letter i (i=0 is first entered) is word[39-8i -: 8].
- PLAY:
  - A guess is processed on each guess_valid cycle.
  - Guesses outside 'A'..'Z', or letters already guessed (26-bit guessed vector), are acknowledged with no other effect.
  - A new letter is marked guessed. If it matches any position, every matching position is revealed. If it matches nothing, mistakes increments.
- Round end:
  - All 5 positions revealed → RESULT with win=1.
  - mistakes reaches MAX_MISTAKES → RESULT with lose=1.
  - Win is checked first; both conditions cannot arise from one guess.
- RESULT: count RESULT_CYCLES cycles. Then pulse game_end for 1 cycle, clear count, guessed vector, mistakes, reveal, win and lose, and return to ENTRY.
- Inputs ignored by state:
  - key_ready and submit outside ENTRY.
  - guess_valid outside PLAY (no ack).
  - word_ready outside LOCK.
- Reset values: state ENTRY, reveal = five 8'h5F, mistakes 0, all strobes/flags 0, count 0, guessed vector 0.

## Timing

- reg_key_ready is combinational from key_ready (same cycle).
- reg_toggle: registered, asserted the cycle after the accepted submit.
- game_end: registered, asserted in the last RESULT cycle. The state is ENTRY on the following cycle.
- Guess at cycle t → guess_ack, reveal, mistakes, win/lose all valid at t+1, and state is RESULT at t+1 if the round ended.
- Back-to-back guesses every cycle are supported. Each is scored against state already including the previous guess.
- Reset asserted mid-round: at the next edge all outputs take reset values. No game_end pulse is generated.
- word_ready already high when entering LOCK is taken on the first LOCK cycle.

## Structure

- Shared package hangman_pkg: state enum, UNDERSCORE = 8'h5F, WORD_LEN = 5, letter-range constants.
- Sub-module hangman_match (combinational): takes the 40-bit word and an 8-bit letter, returns a 5-bit match mask. Also reusable by the player side.

## Test plan

- Enter C,A,T,S,Y, submit, word_ready after 2 cycles → exactly one reg_toggle pulse; PLAY entered; reveal = 5×8'h5F.
- Submit after only 3 letters → no reg_toggle; sixth letter after 5 → reg_key_ready stays 0.
- Word "APPLE", guess 'P' → guess_ack next cycle; reveal = "_PP__"; mistakes 0.
- Word "APPLE", guess 'Z' twice, then '5' → mistakes 1 after both 'Z' guesses; three acks; '5' changes nothing.
- Word "APPLE", six distinct wrong letters → lose=1 after the sixth; game_end pulses RESULT_CYCLES cycles later; next cycle reveal/mistakes cleared, state ENTRY.
- Win on guesses A,P,L,E → win=1 on the cycle after 'E'. Separately, nRst low mid-PLAY → all outputs at reset values with no game_end.
